// File: rtl/dcache_req_rcv_pkg.sv
// Shared types and constants for the dcache request receiver.
// Build option: DCACHE_REQ_RCV_IO_EN enables the single-entry IO request path.
package dcache_req_rcv_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int NBANK     = 32;

  // Payload of one memory request as issued by the AGU.
  typedef struct packed {
    logic [35:0]      addr_even;
    logic [35:0]      addr_odd;
    logic [4:0]       sz;
    logic             st;
    logic [NBANK-1:0] banks;
    logic [4:0]       bank0;
    logic             odd;
    logic [1:0]       addr_low;
    logic             split;
    logic [8:0]       reg_no;
    logic [8:0]       lsq;
    logic [9:0]       ii;
    logic [5:0]       wq;
  } req_data_t;

  // Queue entry: payload plus occupancy and "accepted last cycle" marks.
  typedef struct packed {
    logic      valid;
    logic      new_mark;
    req_data_t data;
  } req_entry_t;

  // True when any bank the request needs is unavailable this cycle.
  function automatic logic bank_conflict(input logic [NBANK-1:0] banks,
                                         input logic [NBANK-1:0] busy);
    return |(banks & busy);
  endfunction

endpackage

// File: rtl/dcache_req_rcv_if.sv
// Request, bank-issue, IO and fault-report signals of the dcache request receiver.
// Build option: DCACHE_REQ_RCV_IO_EN (io_* are only active when it is defined).
interface dcache_req_rcv_if;
  import dcache_req_rcv_pkg::*;

  logic             except;
  logic             mOp_en;
  logic             mOp_ioEn;
  logic [35:0]      mOp_addrEven;
  logic [35:0]      mOp_addrOdd;
  logic [4:0]       mOp_sz;
  logic             mOp_st;
  logic [NBANK-1:0] mOp_banks;
  logic [4:0]       mOp_bank0;
  logic             mOp_odd;
  logic [1:0]       mOp_addr_low;
  logic             mOp_split;
  logic [8:0]       mOp_regNo;
  logic [8:0]       mOp_LSQ;
  logic [9:0]       mOp_II;
  logic [5:0]       mOp_WQ;
  logic             pageFault;
  logic [8:0]       faultNo;
  logic             bus_hold;
  logic [NBANK-1:0] bank_busy;

  logic             out_en;
  logic [35:0]      out_addrEven;
  logic [35:0]      out_addrOdd;
  logic [4:0]       out_sz;
  logic             out_st;
  logic [NBANK-1:0] out_banks;
  logic [4:0]       out_bank0;
  logic             out_odd;
  logic [1:0]       out_addr_low;
  logic             out_split;
  logic [8:0]       out_regNo;
  logic [8:0]       out_LSQ;
  logic [9:0]       out_II;
  logic [5:0]       out_WQ;

  logic             io_req;
  logic             io_ack;
  logic [35:0]      io_addrEven;
  logic [35:0]      io_addrOdd;
  logic [4:0]       io_sz;
  logic             io_st;
  logic [NBANK-1:0] io_banks;
  logic [4:0]       io_bank0;
  logic             io_odd;
  logic [1:0]       io_addr_low;
  logic             io_split;
  logic [8:0]       io_regNo;
  logic [8:0]       io_LSQ;
  logic [9:0]       io_II;
  logic [5:0]       io_WQ;

  logic             fault_en;
  logic [8:0]       fault_regNo;
  logic [8:0]       fault_LSQ;
  logic [8:0]       fault_No;

  modport slave (
    input  except, mOp_en, mOp_ioEn, mOp_addrEven, mOp_addrOdd, mOp_sz, mOp_st,
           mOp_banks, mOp_bank0, mOp_odd, mOp_addr_low, mOp_split, mOp_regNo,
           mOp_LSQ, mOp_II, mOp_WQ, pageFault, faultNo, bank_busy, io_ack,
    output bus_hold, out_en, out_addrEven, out_addrOdd, out_sz, out_st, out_banks,
           out_bank0, out_odd, out_addr_low, out_split, out_regNo, out_LSQ, out_II,
           out_WQ, io_req, io_addrEven, io_addrOdd, io_sz, io_st, io_banks, io_bank0,
           io_odd, io_addr_low, io_split, io_regNo, io_LSQ, io_II, io_WQ,
           fault_en, fault_regNo, fault_LSQ, fault_No
  );

  modport master (
    output except, mOp_en, mOp_ioEn, mOp_addrEven, mOp_addrOdd, mOp_sz, mOp_st,
           mOp_banks, mOp_bank0, mOp_odd, mOp_addr_low, mOp_split, mOp_regNo,
           mOp_LSQ, mOp_II, mOp_WQ, pageFault, faultNo, bank_busy, io_ack,
    input  bus_hold, out_en, out_addrEven, out_addrOdd, out_sz, out_st, out_banks,
           out_bank0, out_odd, out_addr_low, out_split, out_regNo, out_LSQ, out_II,
           out_WQ, io_req, io_addrEven, io_addrOdd, io_sz, io_st, io_banks, io_bank0,
           io_odd, io_addr_low, io_split, io_regNo, io_LSQ, io_II, io_WQ,
           fault_en, fault_regNo, fault_LSQ, fault_No
  );

endinterface

// File: rtl/dcache_req_fifo.sv
// In-order request queue: storage, head/tail pointers, count, valid and new marks.
// Faulted entries are invalidated in place; the top drops them when they reach the head.
module dcache_req_fifo
  import dcache_req_rcv_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   kill_new,
  input  req_data_t              push_data,
  output req_entry_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   new_hit,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [PW-1:0]  head_r;
  logic [PW-1:0]  tail_r;
  logic [PW:0]    count_r;
  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] new_r;
  logic [DEPTH-1:0] valid_nx_s;
  logic [DEPTH-1:0] new_nx_s;
  logic           overflow_r;
  logic           push_ok_s;
  logic           pop_ok_s;
  req_data_t      mem_r [DEPTH];

  assign full     = (count_r == FULL_CNT);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & (|count_r);
  assign count    = count_r;
  assign new_hit  = |(valid_r & new_r);
  assign overflow = overflow_r;
  assign head     = '{valid: valid_r[head_r], new_mark: new_r[head_r], data: mem_r[head_r]};

  // Next valid/new marks: only the entry written this cycle is new next cycle.
  always_comb begin
    valid_nx_s = valid_r;
    new_nx_s   = {DEPTH{1'b0}};
    if (kill_new) begin
      valid_nx_s = valid_r & ~new_r;
    end else begin
      valid_nx_s = valid_r;
    end
    if (pop_ok_s) begin
      valid_nx_s[head_r] = 1'b0;
    end else begin
      valid_nx_s = valid_nx_s;
    end
    if (push_ok_s) begin
      valid_nx_s[tail_r] = 1'b1;
      new_nx_s[tail_r]   = 1'b1;
    end else begin
      new_nx_s = new_nx_s;
    end
  end

  // Pointer, count and mark registers; a flush empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {(PW+1){1'b0}};
      valid_r <= {DEPTH{1'b0}};
      new_r   <= {DEPTH{1'b0}};
    end else if (flush) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {(PW+1){1'b0}};
      valid_r <= {DEPTH{1'b0}};
      new_r   <= {DEPTH{1'b0}};
    end else begin
      valid_r <= valid_nx_s;
      new_r   <= new_nx_s;
      if (push_ok_s) tail_r <= tail_r + PW'(1);
      if (pop_ok_s)  head_r <= head_r + PW'(1);
      count_r <= count_r + {PW'(0), push_ok_s} - {PW'(0), pop_ok_s};
    end
  end

  // Sticky record of a request offered while the queue was full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_r <= 1'b0;
    else     overflow_r <= overflow_r | (push & full & ~flush);
  end

  // Payload storage; qualified by valid_r so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s & ~flush) mem_r[tail_r] <= push_data;
  end

endmodule

// File: rtl/dcache_req_rcv_chk.sv
// Checker for the request receiver: the AGU must never push into a full queue.
module dcache_req_rcv_chk (
  input logic clk,
  input logic rst,
  input logic overflow
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !overflow)
    else $error("dcache_req_rcv: request offered while queue full");

endmodule

// File: rtl/dcache_req_rcv.sv
// Dcache request receiver: queues AGU requests, issues them in order to free banks,
// turns a page fault on the request accepted last cycle into a fault report.
// Build option: DCACHE_REQ_RCV_IO_EN adds the single-entry IO request register.
module dcache_req_rcv
  import dcache_req_rcv_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input logic           clk,
  input logic           rst,
  dcache_req_rcv_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  req_data_t  req_s;
  req_entry_t head_s;
  logic [CW-1:0] count_s;
  logic full_s, new_hit_s, overflow_s;
  logic push_s, q_acc_s, drop_s, pop_s, out_en_s;
  logic io_acc_s, io_valid_s, io_new_hit_s, io_req_s;
  req_data_t io_data_s;
  logic fault_raise_s;
  logic fault_en_r;
  logic [8:0] last_reg_no_r, last_lsq_r;
  logic [8:0] fault_reg_no_r, fault_lsq_r, fault_no_r;

  // Gather the incoming request fields into one payload.
  always_comb begin
    req_s           = '0;
    req_s.addr_even = bus.mOp_addrEven;
    req_s.addr_odd  = bus.mOp_addrOdd;
    req_s.sz        = bus.mOp_sz;
    req_s.st        = bus.mOp_st;
    req_s.banks     = bus.mOp_banks;
    req_s.bank0     = bus.mOp_bank0;
    req_s.odd       = bus.mOp_odd;
    req_s.addr_low  = bus.mOp_addr_low;
    req_s.split     = bus.mOp_split;
    req_s.reg_no    = bus.mOp_regNo;
    req_s.lsq       = bus.mOp_LSQ;
    req_s.ii        = bus.mOp_II;
    req_s.wq        = bus.mOp_WQ;
  end

  assign push_s  = bus.mOp_en & ~bus.except;
  assign q_acc_s = push_s & ~full_s;

  // A faulted head is not issued; once invalidated it is dropped silently.
  assign out_en_s = head_s.valid & ~bank_conflict(head_s.data.banks, bus.bank_busy)
                  & ~(head_s.new_mark & bus.pageFault) & ~bus.except;
  assign drop_s   = (|count_s) & ~head_s.valid;
  assign pop_s    = out_en_s | drop_s;

  dcache_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.except),
    .push      (push_s),
    .pop       (pop_s),
    .kill_new  (bus.pageFault),
    .push_data (req_s),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s),
    .new_hit   (new_hit_s),
    .overflow  (overflow_s)
  );

  dcache_req_rcv_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .overflow (overflow_s)
  );

`ifdef DCACHE_REQ_RCV_IO_EN
  logic io_valid_r, io_new_r;
  req_data_t io_data_r;

  assign io_acc_s     = bus.mOp_ioEn & ~io_valid_r & ~bus.except;
  assign io_valid_s   = io_valid_r;
  assign io_new_hit_s = io_valid_r & io_new_r;
  assign io_req_s     = io_valid_r & ~(io_new_r & bus.pageFault) & ~bus.except;
  assign io_data_s    = io_data_r;

  // IO holding register: loaded once, cleared by ack, fault on accept, or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_valid_r <= 1'b0;
      io_new_r   <= 1'b0;
    end else if (bus.except) begin
      io_valid_r <= 1'b0;
      io_new_r   <= 1'b0;
    end else if (io_acc_s) begin
      io_valid_r <= 1'b1;
      io_new_r   <= 1'b1;
    end else begin
      io_new_r <= 1'b0;
      if (io_new_r & bus.pageFault)  io_valid_r <= 1'b0;
      else if (io_req_s & bus.io_ack) io_valid_r <= 1'b0;
      else                            io_valid_r <= io_valid_r;
    end
  end

  // IO payload; qualified by io_valid_r so it needs no reset.
  always_ff @(posedge clk) begin
    if (io_acc_s) io_data_r <= req_s;
  end
`else
  logic unused_io;
  assign unused_io    = &{1'b0, bus.mOp_ioEn, bus.io_ack};
  assign io_acc_s     = 1'b0;
  assign io_valid_s   = 1'b0;
  assign io_new_hit_s = 1'b0;
  assign io_req_s     = 1'b0;
  assign io_data_s    = '0;
`endif

  // A fault under a pipeline flush is dropped together with the request.
  assign fault_raise_s = bus.pageFault & (new_hit_s | io_new_hit_s) & ~bus.except;

  // Fault report registers plus the tags of the request accepted last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_en_r     <= 1'b0;
      fault_reg_no_r <= 9'd0;
      fault_lsq_r    <= 9'd0;
      fault_no_r     <= 9'd0;
      last_reg_no_r  <= 9'd0;
      last_lsq_r     <= 9'd0;
    end else begin
      fault_en_r <= fault_raise_s;
      if (fault_raise_s) begin
        fault_reg_no_r <= last_reg_no_r;
        fault_lsq_r    <= last_lsq_r;
        fault_no_r     <= bus.faultNo;
      end
      if (q_acc_s | io_acc_s) begin
        last_reg_no_r <= req_s.reg_no;
        last_lsq_r    <= req_s.lsq;
      end
    end
  end

  assign bus.bus_hold    = full_s | io_valid_s;
  assign bus.fault_en    = fault_en_r & ~bus.except;
  assign bus.fault_regNo = fault_reg_no_r;
  assign bus.fault_LSQ   = fault_lsq_r;
  assign bus.fault_No    = fault_no_r;

  assign bus.out_en       = out_en_s;
  assign bus.out_addrEven = head_s.data.addr_even;
  assign bus.out_addrOdd  = head_s.data.addr_odd;
  assign bus.out_sz       = head_s.data.sz;
  assign bus.out_st       = head_s.data.st;
  assign bus.out_banks    = head_s.data.banks;
  assign bus.out_bank0    = head_s.data.bank0;
  assign bus.out_odd      = head_s.data.odd;
  assign bus.out_addr_low = head_s.data.addr_low;
  assign bus.out_split    = head_s.data.split;
  assign bus.out_regNo    = head_s.data.reg_no;
  assign bus.out_LSQ      = head_s.data.lsq;
  assign bus.out_II       = head_s.data.ii;
  assign bus.out_WQ       = head_s.data.wq;

  assign bus.io_req      = io_req_s;
  assign bus.io_addrEven = io_data_s.addr_even;
  assign bus.io_addrOdd  = io_data_s.addr_odd;
  assign bus.io_sz       = io_data_s.sz;
  assign bus.io_st       = io_data_s.st;
  assign bus.io_banks    = io_data_s.banks;
  assign bus.io_bank0    = io_data_s.bank0;
  assign bus.io_odd      = io_data_s.odd;
  assign bus.io_addr_low = io_data_s.addr_low;
  assign bus.io_split    = io_data_s.split;
  assign bus.io_regNo    = io_data_s.reg_no;
  assign bus.io_LSQ      = io_data_s.lsq;
  assign bus.io_II       = io_data_s.ii;
  assign bus.io_WQ       = io_data_s.wq;

endmodule

// File: tb/tb_dcache_req_rcv.sv
// Directed bench for dcache_req_rcv; inputs change on the falling edge and
// outputs are sampled 1 ns later. Build option: DCACHE_REQ_RCV_IO_EN.
module tb_dcache_req_rcv;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dcache_req_rcv_if bus_if();

  dcache_req_rcv #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  task automatic idle();
    bus_if.except    = 1'b0;
    bus_if.mOp_en    = 1'b0;
    bus_if.mOp_ioEn  = 1'b0;
    bus_if.pageFault = 1'b0;
    bus_if.faultNo   = 9'd0;
    bus_if.io_ack    = 1'b0;
  endtask

  task automatic drive_req(input logic io, input logic [8:0] reg_no,
                           input logic [8:0] lsq, input logic [31:0] banks);
    bus_if.mOp_en       = ~io;
    bus_if.mOp_ioEn     = io;
    bus_if.mOp_addrEven = {27'h0, reg_no};
    bus_if.mOp_addrOdd  = {27'h1, reg_no};
    bus_if.mOp_sz       = 5'd3;
    bus_if.mOp_st       = 1'b0;
    bus_if.mOp_banks    = banks;
    bus_if.mOp_bank0    = 5'd0;
    bus_if.mOp_odd      = 1'b0;
    bus_if.mOp_addr_low = 2'd1;
    bus_if.mOp_split    = 1'b0;
    bus_if.mOp_regNo    = reg_no;
    bus_if.mOp_LSQ      = lsq;
    bus_if.mOp_II       = {1'b0, reg_no};
    bus_if.mOp_WQ       = 6'd5;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus_if.bank_busy = 32'h0;
    drive_req(1'b0, 9'h001, 9'h001, 32'h1);
    @(negedge clk); #1;
    checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL reset_out_en: got %b want 0", bus_if.out_en); end
    checks++; if (bus_if.bus_hold !== 1'b0) begin errors++; $display("FAIL reset_bus_hold: got %b want 0", bus_if.bus_hold); end
    checks++; if (bus_if.io_req !== 1'b0) begin errors++; $display("FAIL reset_io_req: got %b want 0", bus_if.io_req); end
    checks++; if (bus_if.fault_en !== 1'b0) begin errors++; $display("FAIL reset_fault_en: got %b want 0", bus_if.fault_en); end
    checks++; if (dut.count_s !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", dut.count_s); end
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  task automatic test_single_load();
    @(negedge clk); drive_req(1'b0, 9'h011, 9'h022, 32'h3); bus_if.bank_busy = 32'h0; #1;
    checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", bus_if.out_en); end
    @(negedge clk); idle(); #1;
    checks++; if (bus_if.out_en !== 1'b1) begin errors++; $display("FAIL single_out_en: got %b want 1", bus_if.out_en); end
    checks++; if (bus_if.out_banks !== 32'h3) begin errors++; $display("FAIL single_banks: got %h want 3", bus_if.out_banks); end
    checks++; if (bus_if.out_regNo !== 9'h011) begin errors++; $display("FAIL single_regNo: got %h want 011", bus_if.out_regNo); end
    checks++; if (bus_if.out_addrEven !== 36'h11) begin errors++; $display("FAIL single_addr: got %h want 11", bus_if.out_addrEven); end
    @(negedge clk); #1;
    checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL single_once: got %b want 0", bus_if.out_en); end
    checks++; if (dut.count_s !== 3'd0) begin errors++; $display("FAIL single_count: got %0d want 0", dut.count_s); end
  endtask

  task automatic test_fault();
    @(negedge clk); drive_req(1'b0, 9'h0A5, 9'h15A, 32'h1); #1;
    @(negedge clk); idle(); bus_if.pageFault = 1'b1; bus_if.faultNo = 9'h059; #1;
    checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL fault_no_issue: got %b want 0", bus_if.out_en); end
    checks++; if (bus_if.fault_en !== 1'b0) begin errors++; $display("FAIL fault_early: got %b want 0", bus_if.fault_en); end
    @(negedge clk); idle(); #1;
    checks++; if (bus_if.fault_en !== 1'b1) begin errors++; $display("FAIL fault_en: got %b want 1", bus_if.fault_en); end
    checks++; if (bus_if.fault_regNo !== 9'h0A5) begin errors++; $display("FAIL fault_regNo: got %h want 0a5", bus_if.fault_regNo); end
    checks++; if (bus_if.fault_LSQ !== 9'h15A) begin errors++; $display("FAIL fault_LSQ: got %h want 15a", bus_if.fault_LSQ); end
    checks++; if (bus_if.fault_No !== 9'h059) begin errors++; $display("FAIL fault_No: got %h want 059", bus_if.fault_No); end
    checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL fault_drop: got %b want 0", bus_if.out_en); end
    @(negedge clk); #1;
    checks++; if (bus_if.fault_en !== 1'b0) begin errors++; $display("FAIL fault_pulse: got %b want 0", bus_if.fault_en); end
    checks++; if (dut.count_s !== 3'd0) begin errors++; $display("FAIL fault_count: got %0d want 0", dut.count_s); end
  endtask

  task automatic test_back_to_back();
    logic exp_hold;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive_req(1'b0, 9'(9'h100 + i), 9'(9'h040 + i), 32'h1); bus_if.bank_busy = 32'hFFFFFFFF; #1;
      checks++; if (bus_if.bus_hold !== 1'b0) begin errors++; $display("FAIL b2b_hold_fill%0d: got %b want 0", i, bus_if.bus_hold); end
    end
    @(negedge clk); idle(); #1;
    checks++; if (bus_if.bus_hold !== 1'b1) begin errors++; $display("FAIL b2b_hold_full: got %b want 1", bus_if.bus_hold); end
    checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", bus_if.out_en); end
    checks++; if (dut.count_s !== 3'd4) begin errors++; $display("FAIL b2b_count: got %0d want 4", dut.count_s); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus_if.bank_busy = 32'h0; #1;
      exp_hold = (i == 0);
      checks++; if (bus_if.out_en !== 1'b1) begin errors++; $display("FAIL b2b_out_en%0d: got %b want 1", i, bus_if.out_en); end
      checks++; if (bus_if.out_regNo !== 9'(9'h100 + i)) begin errors++; $display("FAIL b2b_order%0d: got %h want %h", i, bus_if.out_regNo, 9'(9'h100 + i)); end
      checks++; if (bus_if.bus_hold !== exp_hold) begin errors++; $display("FAIL b2b_hold%0d: got %b want %b", i, bus_if.bus_hold, exp_hold); end
    end
    @(negedge clk); #1;
    checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", bus_if.out_en); end
  endtask

  task automatic test_bank_conflict();
    @(negedge clk); drive_req(1'b0, 9'h0AA, 9'h0A0, 32'h10); bus_if.bank_busy = 32'h10; #1;
    @(negedge clk); drive_req(1'b0, 9'h0BB, 9'h0B0, 32'h01); bus_if.bank_busy = 32'h10; #1;
    checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL conflict_c1: got %b want 0", bus_if.out_en); end
    for (int i = 2; i < 4; i++) begin
      @(negedge clk); idle(); bus_if.bank_busy = 32'h10; #1;
      checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL conflict_c%0d: got %b want 0", i, bus_if.out_en); end
    end
    @(negedge clk); bus_if.bank_busy = 32'h0; #1;
    checks++; if (bus_if.out_en !== 1'b1) begin errors++; $display("FAIL conflict_issue: got %b want 1", bus_if.out_en); end
    checks++; if (bus_if.out_regNo !== 9'h0AA) begin errors++; $display("FAIL conflict_head: got %h want 0aa", bus_if.out_regNo); end
    @(negedge clk); #1;
    checks++; if (bus_if.out_en !== 1'b1) begin errors++; $display("FAIL conflict_second: got %b want 1", bus_if.out_en); end
    checks++; if (bus_if.out_regNo !== 9'h0BB) begin errors++; $display("FAIL conflict_younger: got %h want 0bb", bus_if.out_regNo); end
    @(negedge clk); #1;
    checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL conflict_done: got %b want 0", bus_if.out_en); end
  endtask

  task automatic test_except();
    logic exp_hold;
`ifdef DCACHE_REQ_RCV_IO_EN
    exp_hold = 1'b1;
`else
    exp_hold = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_req(1'b0, 9'(9'h1C0 + i), 9'(9'h0C0 + i), 32'h2); bus_if.bank_busy = 32'hFFFFFFFF; #1;
    end
    @(negedge clk); idle(); drive_req(1'b1, 9'h1E0, 9'h0E0, 32'h4); #1;
    @(negedge clk); idle(); bus_if.bank_busy = 32'h0; bus_if.except = 1'b1; bus_if.pageFault = 1'b1; bus_if.faultNo = 9'h033; #1;
    checks++; if (bus_if.bus_hold !== exp_hold) begin errors++; $display("FAIL except_hold_before: got %b want %b", bus_if.bus_hold, exp_hold); end
    checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL except_out_en: got %b want 0", bus_if.out_en); end
    checks++; if (bus_if.io_req !== 1'b0) begin errors++; $display("FAIL except_io_req: got %b want 0", bus_if.io_req); end
    @(negedge clk); idle(); #1;
    checks++; if (dut.count_s !== 3'd0) begin errors++; $display("FAIL except_count: got %0d want 0", dut.count_s); end
    checks++; if (bus_if.io_req !== 1'b0) begin errors++; $display("FAIL except_io_clear: got %b want 0", bus_if.io_req); end
    checks++; if (bus_if.bus_hold !== 1'b0) begin errors++; $display("FAIL except_hold_after: got %b want 0", bus_if.bus_hold); end
    checks++; if (bus_if.fault_en !== 1'b0) begin errors++; $display("FAIL except_fault: got %b want 0", bus_if.fault_en); end
    checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL except_no_issue: got %b want 0", bus_if.out_en); end
  endtask

  task automatic test_io();
    @(negedge clk); idle(); bus_if.bank_busy = 32'h0; drive_req(1'b1, 9'h1E1, 9'h0E1, 32'h8); #1;
    checks++; if (bus_if.io_req !== 1'b0) begin errors++; $display("FAIL io_early: got %b want 0", bus_if.io_req); end
`ifdef DCACHE_REQ_RCV_IO_EN
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); idle(); bus_if.io_ack = (i == 6); #1;
      checks++; if (bus_if.io_req !== 1'b1) begin errors++; $display("FAIL io_req_c%0d: got %b want 1", i, bus_if.io_req); end
      checks++; if (bus_if.bus_hold !== 1'b1) begin errors++; $display("FAIL io_hold_c%0d: got %b want 1", i, bus_if.bus_hold); end
      checks++; if (bus_if.io_regNo !== 9'h1E1) begin errors++; $display("FAIL io_regNo_c%0d: got %h want 1e1", i, bus_if.io_regNo); end
    end
    checks++; if (bus_if.io_addrEven !== 36'h1E1) begin errors++; $display("FAIL io_addr: got %h want 1e1", bus_if.io_addrEven); end
    @(negedge clk); idle(); #1;
    checks++; if (bus_if.io_req !== 1'b0) begin errors++; $display("FAIL io_cleared: got %b want 0", bus_if.io_req); end
    checks++; if (bus_if.bus_hold !== 1'b0) begin errors++; $display("FAIL io_hold_cleared: got %b want 0", bus_if.bus_hold); end
`else
    @(negedge clk); idle(); bus_if.io_ack = 1'b1; #1;
    checks++; if (bus_if.io_req !== 1'b0) begin errors++; $display("FAIL io_ignored: got %b want 0", bus_if.io_req); end
    checks++; if (bus_if.bus_hold !== 1'b0) begin errors++; $display("FAIL io_hold_ignored: got %b want 0", bus_if.bus_hold); end
    checks++; if (bus_if.io_regNo !== 9'h000) begin errors++; $display("FAIL io_tied: got %h want 000", bus_if.io_regNo); end
    checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL io_not_queued: got %b want 0", bus_if.out_en); end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive_req(1'b0, 9'(9'h0D0 + i), 9'h0D0, 32'h1); bus_if.bank_busy = 32'hFFFFFFFF; #1;
    end
    @(negedge clk); idle(); rst = 1'b1; bus_if.bank_busy = 32'h0; #1;
    checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL rstmid_out_en: got %b want 0", bus_if.out_en); end
    checks++; if (dut.count_s !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", dut.count_s); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (bus_if.out_en !== 1'b0) begin errors++; $display("FAIL rstmid_after: got %b want 0", bus_if.out_en); end
    checks++; if (bus_if.fault_en !== 1'b0) begin errors++; $display("FAIL rstmid_fault: got %b want 0", bus_if.fault_en); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_load();
    test_fault();
    test_back_to_back();
    test_bank_conflict();
    test_except();
    test_io();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_req_rcv.md
DCACHE_REQ_RCV -- requirements
Module: dcache_req_rcv

Interface
REQ-001 Parameter: DEPTH, 4, request queue entries; power of two, at least 2.
REQ-002 The design SHALL have one clock, clk. Reset rst SHALL be asynchronous and active-high.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- except  in  1  pipeline flush
- mOp_en  in  1  cacheable request valid
- mOp_ioEn  in  1  IO request valid
- mOp_addrEven, mOp_addrOdd  in  36 each  physical line address bits [43:8]
- mOp_sz  in  5  size code
- mOp_st  in  1  store
- mOp_banks  in  32  bank mask
- mOp_bank0  in  5  first bank
- mOp_odd  in  1  odd line
- mOp_addr_low  in  2  low address bits
- mOp_split  in  1  line-crossing request
- mOp_regNo  in  9  register tag
- mOp_LSQ  in  9  LSQ tag
- mOp_II  in  10  instruction index
- mOp_WQ  in  6  write-queue tag
- pageFault  in  1  fault for the request accepted the previous cycle
- faultNo  in  9  fault number
- bus_hold  out  1  backpressure to the issuing AGU
- bank_busy  in  32  banks unavailable this cycle
- out_en  out  1  request issued to the banks
- out_*  out  widths as the mOp_* inputs  fields of the issued request
- io_req  out  1  IO request pending
- io_ack  in  1  IO request taken
- io_*  out  widths as the mOp_* inputs  fields of the IO request
- fault_en  out  1  fault report pulse
- fault_regNo  out  9  tag of the faulting request
- fault_LSQ  out  9  tag of the faulting request
- fault_No  out  9  fault number of the faulting request

Function
REQ-004 When mOp_en is high in cycle N, all fields SHALL be written to the queue tail and marked new.
REQ-005 The new mark SHALL clear at the end of cycle N+1.
REQ-006 If pageFault is high in cycle N+1, the new entry (queue or IO) SHALL be invalidated without issue.
REQ-007 After a faulted entry, fault_en SHALL pulse in cycle N+2 with fault_regNo, fault_LSQ and fault_No of that entry.
REQ-008 out_en SHALL assert when all of the following hold: head valid; (head.banks & bank_busy) == 0; not (head new and pageFault); except low.
REQ-009 The head SHALL dequeue in the cycle out_en is high; out_* SHALL show head fields combinationally.
REQ-010 Minimum latency SHALL be 1 cycle (accept in N, out_en in N+1). Issue SHALL be in order, at most 1 per cycle.
REQ-011 The queue SHALL accept simultaneous enqueue and dequeue. The count SHALL be unchanged in that case.
REQ-012 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH. The count SHALL be log2(DEPTH)+1 bits.
REQ-013 bus_hold SHALL equal (count == DEPTH) OR io_valid, driven from registered state only.
REQ-014 mOp_en while full SHALL be ignored and SHALL set an assertion-only overflow flag.
REQ-015 When except is high, all entries, io_valid and pending fault reports SHALL be cleared by the next cycle.
REQ-016 While except is high, out_en, io_req and fault_en SHALL be 0.
REQ-017 A fault raised in the cycle except is high SHALL be dropped.

Reset
REQ-018 On rst: pointers and count SHALL be 0, all valid and new bits 0, io_valid 0.
REQ-019 During reset: bus_hold, out_en, io_req and fault_en SHALL be 0. Data fields need not be reset.
REQ-020 rst mid-transfer SHALL drop all requests with no output pulse.

Configuration
REQ-021 Macro DCACHE_REQ_RCV_IO_EN controls the IO path.
REQ-022 With DCACHE_REQ_RCV_IO_EN defined: mOp_ioEn SHALL load a single IO register (io_valid, new mark).
REQ-023 With the macro defined: io_req = io_valid & ~(io_new & pageFault) & ~except; io_valid SHALL clear when io_req & io_ack.
REQ-024 Without the macro: mOp_ioEn and io_ack SHALL be ignored; io_req and io_* SHALL be tied 0; bus_hold SHALL reflect queue full only.

Structure
REQ-025 A shared package SHALL hold the request entry struct (all mOp fields plus valid/new), the DEPTH default and the bank count constant 32.
REQ-026 One sub-module, dcache_req_fifo, SHALL implement the pointer/count storage. Fault/IO logic SHALL stay in the top.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Single load, banks=0x3, bank_busy=0, pageFault=0 -> out_en exactly 1 cycle later, out_banks=0x3, count back to 0.
- Accept in N, pageFault=1 in N+1 with faultNo=9'h59 -> no out_en; fault_en in N+2, fault_regNo/fault_LSQ of that entry, fault_No=9'h59.
- Four back-to-back requests with bank_busy=0xFFFFFFFF -> bus_hold high after 4th; bank_busy=0 -> 4 in-order out_en pulses; bus_hold drops after 1st dequeue.
- Head banks=0x10 with bank_busy=0x10 for 3 cycles -> out_en held low 3 cycles, then issue; younger entry not issued before head.
- except with 3 entries queued and IO pending -> next cycle count=0, io_req=0, bus_hold=0, no fault_en.
- IO_EN build: mOp_ioEn, io_ack delayed 5 cycles -> io_req high cycles N+1..N+6, bus_hold high throughout, clears after ack.
